// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks i/j/k over row-major A and B buffers, accumulates
// each dot product from one-cycle-latency reads and writes it into C.
// Optional feature macro: MATMUL_SEQ_SAT_EN (saturating accumulation).
// Without it the accumulator wraps modulo 2^ACCW.
module matmul_sequencer #(
    parameter int MAX_N = 8,
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter int ACCW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [3:0]      matrix_size,
    output logic            busy,
    output logic            done,
    output logic            err_size,
    output logic            a_rd_en,
    output logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_rd_data,
    output logic            b_rd_en,
    output logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_rd_data,
    output logic            c_wr_en,
    output logic [AW-1:0]   c_addr,
    output logic [ACCW-1:0] c_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [4:0] MAX_N_W = 5'(MAX_N);

    state_t          state_q, state_d;
    logic [3:0]      n_q, n_d;
    logic [3:0]      i_q, i_d;
    logic [3:0]      j_q, j_d;
    logic [3:0]      k_q, k_d;
    logic [ACCW-1:0] acc_q, acc_d;
    // pend: read data arrives this cycle; pend_first: that data is for k=0
    logic            pend_q, pend_d;
    logic            pend_first_q, pend_first_d;
    logic            rd_first_q, rd_first_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_size_q, err_size_d;
    logic            rd_en_q, rd_en_d;
    logic [AW-1:0]   a_addr_q, a_addr_d;
    logic [AW-1:0]   b_addr_q, b_addr_d;
    logic            c_wr_en_q, c_wr_en_d;
    logic [AW-1:0]   c_addr_q, c_addr_d;
    logic [ACCW-1:0] c_wr_data_q, c_wr_data_d;

    logic [2*DW-1:0] prod_full;
    logic [ACCW-1:0] prod_ext;
    logic [ACCW-1:0] acc_base;
    logic [ACCW-1:0] acc_new;
    logic            size_ok;

`ifdef MATMUL_SEQ_SAT_EN
    logic            sat_q, sat_d;
    logic            sat_new;
    logic [ACCW:0]   sum_w;
`endif

    // Product and next accumulator value for the data arriving this cycle
    always_comb begin
        prod_full = (2*DW)'(a_rd_data) * (2*DW)'(b_rd_data);
        prod_ext  = ACCW'(prod_full);
        acc_base  = pend_first_q ? '0 : acc_q;
`ifdef MATMUL_SEQ_SAT_EN
        sum_w   = {1'b0, acc_base} + {1'b0, prod_ext};
        sat_new = (pend_first_q ? 1'b0 : sat_q) | sum_w[ACCW];
        acc_new = sat_new ? '1 : sum_w[ACCW-1:0];
`else
        acc_new = acc_base + prod_ext;
`endif
    end

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        i_d          = i_q;
        j_d          = j_q;
        k_d          = k_q;
        acc_d        = acc_q;
        pend_d       = rd_en_q;
        pend_first_d = rd_first_q;
        err_size_d   = 1'b0;
        size_ok      = (matrix_size != 4'd0) && ({1'b0, matrix_size} <= MAX_N_W);
`ifdef MATMUL_SEQ_SAT_EN
        sat_d        = sat_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (size_ok) begin
                        n_d     = matrix_size;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        state_d = S_FETCH;
                    end else begin
                        err_size_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (k_q == n_q - 4'd1) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                k_d = '0;
                if (j_q == n_q - 4'd1) begin
                    j_d = '0;
                    if (i_q == n_q - 4'd1) begin
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + 4'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    j_d     = j_q + 4'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pend_q) begin
            acc_d = acc_new;
`ifdef MATMUL_SEQ_SAT_EN
            sat_d = sat_new;
`endif
        end

        // Abort kills the sequence and any in-flight read data
        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            acc_d        = '0;
            pend_d       = 1'b0;
            pend_first_d = 1'b0;
`ifdef MATMUL_SEQ_SAT_EN
            sat_d        = 1'b0;
`endif
        end

        // Outputs are decoded from the next state so they register in step
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        rd_en_d     = (state_d == S_FETCH);
        rd_first_d  = rd_en_d && (k_d == 4'd0);
        c_wr_en_d   = (state_d == S_WRITE);
        a_addr_d    = a_addr_q;
        b_addr_d    = b_addr_q;
        c_addr_d    = c_addr_q;
        c_wr_data_d = c_wr_data_q;
        if (rd_en_d) begin
            a_addr_d = AW'(i_d) * AW'(n_d) + AW'(k_d);
            b_addr_d = AW'(k_d) * AW'(n_d) + AW'(j_d);
        end
        if (c_wr_en_d) begin
            c_addr_d    = AW'(i_d) * AW'(n_d) + AW'(j_d);
            c_wr_data_d = acc_d;
        end
    end

    // State, counters, accumulator and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            pend_q       <= 1'b0;
            pend_first_q <= 1'b0;
            rd_first_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_size_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            a_addr_q     <= '0;
            b_addr_q     <= '0;
            c_wr_en_q    <= 1'b0;
            c_addr_q     <= '0;
            c_wr_data_q  <= '0;
`ifdef MATMUL_SEQ_SAT_EN
            sat_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            i_q          <= i_d;
            j_q          <= j_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            pend_q       <= pend_d;
            pend_first_q <= pend_first_d;
            rd_first_q   <= rd_first_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_size_q   <= err_size_d;
            rd_en_q      <= rd_en_d;
            a_addr_q     <= a_addr_d;
            b_addr_q     <= b_addr_d;
            c_wr_en_q    <= c_wr_en_d;
            c_addr_q     <= c_addr_d;
            c_wr_data_q  <= c_wr_data_d;
`ifdef MATMUL_SEQ_SAT_EN
            sat_q        <= sat_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_size  = err_size_q;
    assign a_rd_en   = rd_en_q;
    assign b_rd_en   = rd_en_q;
    assign a_addr    = a_addr_q;
    assign b_addr    = b_addr_q;
    assign c_wr_en   = c_wr_en_q;
    assign c_addr    = c_addr_q;
    assign c_wr_data = c_wr_data_q;

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Sequencing engine for the matrix-multiply datapath. It sits between the host-side control FSM and the A/B/C element buffers. On a `start` pulse it latches the matrix size, then walks i/j/k over row-major A and B with one-cycle-latency reads and accumulates each dot product. It writes each C element, then pulses `done`; it also raises the multiply-complete condition the control FSM waits on before result transmission.

## Interface
- `MAX_N`, 8: largest legal matrix dimension.
- `AW`, 6: buffer address width; MAX_N*MAX_N ≤ 2^AW.
- `DW`, 8: A/B element width, unsigned.
- `ACCW`, 16: accumulator and C element width.

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin multiply; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; return to IDLE.
- `matrix_size`  in  4  dimension n, latched at accepted start.
- `busy`  out  1  high from cycle after accepted start until done cycle inclusive.
- `done`  out  1  one-cycle pulse, all C written.
- `err_size`  out  1  one-cycle pulse, start rejected (n=0 or n>MAX_N).
- `a_rd_en` / `a_addr`  out  1 / AW  A read request, addr = i*n+k.
- `a_rd_data`  in  DW  A data, valid cycle after `a_rd_en`.
- `b_rd_en` / `b_addr`  out  1 / AW  B read request, addr = k*n+j.
- `b_rd_data`  in  DW  B data, valid cycle after `b_rd_en`.
- `c_wr_en` / `c_addr` / `c_wr_data`  out  1 / AW / ACCW  C write, addr = i*n+j.

## Operation
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE, `start`=1, 1≤n≤MAX_N → latch n, clear i, j, k → FETCH. Invalid n → `err_size` pulse next cycle; stay IDLE; no reads.
- FETCH: assert `a_rd_en`/`b_rd_en` every cycle, k=0..n-1. After k=n-1 → DRAIN.
- Accumulate: the cycle after each read, acc ← product when k was 0, else acc + product. Product is DW×DW unsigned, 2*DW bits, truncated/extended to ACCW.
- DRAIN: last product accumulated; no reads → WRITE.
- WRITE: `c_wr_en`=1, `c_wr_data`=acc, `c_addr`=i*n+j. Advance j; on j=n-1 wrap j to 0 and advance i. Last element (i=j=n-1) → DONE, else → FETCH with k=0.
- DONE: `done`=1 for one cycle → IDLE.
- Accumulator overflow wraps modulo 2^ACCW unless the Configuration macro is defined.
- `start` outside IDLE is ignored. `matrix_size` changes after latch are ignored.
- `abort` in any non-IDLE state → IDLE at the next edge. No further reads or writes, no `done`, acc cleared. `abort` and `start` together in IDLE: abort wins, start dropped.

## Timing
- Reset (async, immediate): state IDLE; `busy`, `done`, `err_size`, `a_rd_en`, `b_rd_en`, `c_wr_en` = 0; all addresses, `c_wr_data`, and acc = 0.
- All outputs registered or decoded from registered state; no combinational path from any input to any output.
- `start` sampled at edge 0 → first FETCH cycle 1.
- Per C element: n+2 cycles (n FETCH, 1 DRAIN, 1 WRITE).
- `done` in cycle n*n*(n+2)+1. The next `start` is accepted in the cycle after `done`.
- Reset deasserting mid-sequence: restart in IDLE; no partial state survives.

## Configuration
- `MATMUL_SEQ_SAT_EN` defined: accumulation saturates at 2^ACCW-1. Once saturated, the element stays saturated; saturation is cleared at k=0 of the next element.
- Not defined: plain modulo-2^ACCW wrap; no saturation logic synthesized.

## Test plan
- n=2, A=[1 2;3 4], B=[5 6;7 8] → C writes addr0..3 = 19, 22, 43, 50 in order; `done` at cycle 17; `busy` low at cycle 18.
- n=1, A=7, B=9 → single write addr0=63 in cycle 3; `done` at cycle 4.
- n=2, all A=B=255 → each element 130050. Without macro: `c_wr_data`=0xFC02. With `MATMUL_SEQ_SAT_EN`: `c_wr_data`=0xFFFF.
- start with n=0, then n=9 (MAX_N=8) → `err_size` pulse each time; `busy`, `a_rd_en`, `b_rd_en`, `c_wr_en` stay 0.
- n=3, `abort` at cycle 10 → from cycle 11 `busy`=0 and no reads/writes; `done` never pulses. A following start with n=2 then gives correct C (19, 22, 43, 50 using the first test's matrices).
- n=3 in progress: second `start` at cycle 5 → ignored, 9 writes total. `rst_n` low at cycle 20 → all outputs 0 in the same cycle, state IDLE.
